// File: rtl/dmac_pkg.sv
// dmac_pkg: shared FSM states, burst limits and AXI encodings for the DMA copy engine
package dmac_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RREQ,
        S_RDATA,
        S_WREQ,
        S_WDATA,
        S_WAIT_B,
        S_DONE
    } state_e;

    localparam int MAX_BEATS = 16;
    localparam int PTR_W = $clog2(MAX_BEATS) + 1;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B = 3'd2;
    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Beats left before the next 64 B boundary, capped by the words still to move.
    function automatic logic [PTR_W-1:0] burst_beats(input logic [PTR_W-2:0] off, input logic [13:0] rem);
        logic [PTR_W-1:0] space;
        space = PTR_W'(MAX_BEATS) - {1'b0, off};
        return (rem < 14'(space)) ? rem[PTR_W-1:0] : space;
    endfunction

endpackage

// File: rtl/dmac_beat_buffer.sv
// dmac_beat_buffer: one-burst staging store between the read and write halves of a copy
module dmac_beat_buffer
    import dmac_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [PTR_W-1:0]      wr_ptr,
    output logic [PTR_W-1:0]      rd_ptr
);

    logic [DATA_WIDTH-1:0] mem_q [MAX_BEATS];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

    // Pointers restart at zero for every burst.
    always_comb begin
        wr_ptr_d = clr ? '0 : wr_ptr_q + PTR_W'(wr_en);
        rd_ptr_d = clr ? '0 : rd_ptr_q + PTR_W'(rd_en);
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; only written slots are ever read.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[PTR_W-2:0]] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q[PTR_W-2:0]];
    assign wr_ptr  = wr_ptr_q;
    assign rd_ptr  = rd_ptr_q;

endmodule

// File: rtl/dmac_engine.sv
// dmac_engine: single-channel AXI copy engine; define DMAC_ENGINE_RESP_CHECK_EN to flag non-OKAY responses
module dmac_engine
    import dmac_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   src_addr,
    input  logic [ADDR_WIDTH-1:0]   dst_addr,
    input  logic [15:0]             byte_len,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [ID_WIDTH-1:0]     awid,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [ID_WIDTH-1:0]     wid,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    output logic                    bready,
    input  logic [ID_WIDTH-1:0]     bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic [ID_WIDTH-1:0]     arid,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    output logic                    rready,
    input  logic [ID_WIDTH-1:0]     rid,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid
);

    state_e state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
    logic [13:0] rem_q, rem_d;
    logic busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic arvalid_q, arvalid_d, rready_q, rready_d, awvalid_q, awvalid_d;
    logic wvalid_q, wvalid_d, bready_q, bready_d;
    logic [PTR_W-1:0] beats, wr_ptr, rd_ptr;
    logic [ADDR_WIDTH-1:0] step;
    logic [DATA_WIDTH-1:0] buf_data;
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs, last_r, last_w;
    logic unused_inputs;

    assign beats  = burst_beats(src_q[5:2], rem_q);
    assign step   = ADDR_WIDTH'({beats, 2'b00});
    assign ar_hs  = arvalid_q & arready;
    assign r_hs   = rready_q & rvalid;
    assign aw_hs  = awvalid_q & awready;
    assign w_hs   = wvalid_q & wready;
    assign b_hs   = bready_q & bvalid;
    assign last_r = wr_ptr == beats - PTR_W'(1);
    assign last_w = rd_ptr == beats - PTR_W'(1);

    dmac_beat_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q == S_RREQ),
        .wr_en   (r_hs),
        .wr_data (rdata),
        .rd_en   (w_hs),
        .rd_data (buf_data),
        .wr_ptr  (wr_ptr),
        .rd_ptr  (rd_ptr)
    );

    // Next-state, address bookkeeping and registered handshake outputs.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        rem_d     = rem_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        case (state_q)
            S_IDLE: if (start) begin
                src_d  = {src_addr[ADDR_WIDTH-1:2], 2'b00};
                dst_d  = {dst_addr[ADDR_WIDTH-1:2], 2'b00};
                rem_d  = byte_len[15:2];
                err_d  = 1'b0;
                busy_d = 1'b1;
                if (byte_len[15:2] == '0) state_d = S_DONE;
                else begin
                    state_d   = S_RREQ;
                    arvalid_d = 1'b1;
                end
            end
            S_RREQ: if (ar_hs) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
                state_d   = S_RDATA;
            end
            S_RDATA: if (r_hs) begin
`ifdef DMAC_ENGINE_RESP_CHECK_EN
                if (rresp != RESP_OKAY) err_d = 1'b1;
`endif
                if (last_r) begin
                    rready_d  = 1'b0;
                    awvalid_d = 1'b1;
                    state_d   = S_WREQ;
                end
            end
            S_WREQ: if (aw_hs) begin
                awvalid_d = 1'b0;
                wvalid_d  = 1'b1;
                state_d   = S_WDATA;
            end
            S_WDATA: if (w_hs && last_w) begin
                wvalid_d = 1'b0;
                bready_d = 1'b1;
                state_d  = S_WAIT_B;
            end
            S_WAIT_B: if (b_hs) begin
                bready_d = 1'b0;
                src_d    = src_q + step;
                dst_d    = dst_q + step;
                rem_d    = rem_q - 14'(beats);
`ifdef DMAC_ENGINE_RESP_CHECK_EN
                if (bresp != RESP_OKAY) err_d = 1'b1;
`endif
                if (rem_d == '0 || err_d) state_d = S_DONE;
                else begin
                    state_d   = S_RREQ;
                    arvalid_d = 1'b1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts any burst in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            rem_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            rem_q     <= rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = err_q;
    assign arid    = '0;
    assign araddr  = src_q;
    assign arlen   = 8'(beats - PTR_W'(1));
    assign arsize  = SIZE_4B;
    assign arburst = BURST_INCR;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;
    assign awid    = '0;
    assign awaddr  = dst_q;
    assign awlen   = 8'(beats - PTR_W'(1));
    assign awsize  = SIZE_4B;
    assign awburst = BURST_INCR;
    assign awvalid = awvalid_q;
    assign wid     = '0;
    assign wdata   = buf_data;
    assign wstrb   = '1;
    assign wlast   = wvalid_q & last_w;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;

`ifdef DMAC_ENGINE_RESP_CHECK_EN
    assign unused_inputs = ^{bid, rid, rlast};
`else
    assign unused_inputs = ^{bid, rid, rlast, rresp, bresp};
`endif

endmodule

// File: tb/tb_dmac_engine.sv
// tb_dmac_engine: directed bench for dmac_engine with an AXI slave memory model
module tb_dmac_engine;

    logic clk, rst, start, busy, done, error;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] byte_len;
    logic [3:0] awid, wid, bid, arid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0] awlen, arlen;
    logic [2:0] awsize, arsize;
    logic [1:0] awburst, arburst, bresp, rresp;
    logic [3:0] wstrb;
    logic awvalid, awready, wlast, wvalid, wready, bready, bvalid;
    logic arvalid, arready, rready, rlast, rvalid;

    int checks = 0;
    int errors = 0;

    logic [31:0] smem [0:16383];
    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    logic [31:0] ar_log[$], aw_log[$];
    logic [7:0] arlen_log[$], awlen_log[$];
    bit rnd = 0;
    bit force_v = 0;
    int bresp_err_at = -1;

    dmac_engine dut (
        .clk(clk), .rst(rst), .src_addr(src_addr), .dst_addr(dst_addr), .byte_len(byte_len),
        .start(start), .busy(busy), .done(done), .error(error),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bready(bready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] pat(input logic [31:0] a);
        return 32'h5A00_0000 ^ {a[15:0], ~a[15:0]};
    endfunction

    // AXI slave memory: samples handshakes at negedge, updates and drives 1 time unit after posedge.
    initial begin : slave
        bit s_ar, s_r, s_aw, s_w, s_b, h_ar, h_aw, h_w, r_act, w_act, b_pend;
        logic [31:0] c_araddr, c_awaddr, c_wdata, r_addr, w_addr;
        logic [7:0] c_arlen, c_awlen;
        logic c_wlast;
        logic [44:0] p_ar, p_aw;
        logic [36:0] p_w;
        int r_left, w_left;
        h_ar = 0; h_aw = 0; h_w = 0; r_act = 0; w_act = 0; b_pend = 0;
        r_addr = 0; w_addr = 0; r_left = 0; w_left = 0;
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
        rdata = 0; rresp = 0; rlast = 0; rid = 0; bresp = 0; bid = 0;
        forever begin
            @(negedge clk);
            if (h_ar) begin
                checks++;
                if (arvalid !== 1'b1 || {araddr, arlen, arsize, arburst} !== p_ar) begin
                    errors++;
                    $display("FAIL ar_stable: got valid=%b payload=%h required valid=1 payload=%h", arvalid, {araddr, arlen, arsize, arburst}, p_ar);
                end
            end
            if (h_aw) begin
                checks++;
                if (awvalid !== 1'b1 || {awaddr, awlen, awsize, awburst} !== p_aw) begin
                    errors++;
                    $display("FAIL aw_stable: got valid=%b payload=%h required valid=1 payload=%h", awvalid, {awaddr, awlen, awsize, awburst}, p_aw);
                end
            end
            if (h_w) begin
                checks++;
                if (wvalid !== 1'b1 || {wdata, wstrb, wlast} !== p_w) begin
                    errors++;
                    $display("FAIL w_stable: got valid=%b payload=%h required valid=1 payload=%h", wvalid, {wdata, wstrb, wlast}, p_w);
                end
            end
            h_ar = arvalid && !arready; p_ar = {araddr, arlen, arsize, arburst};
            h_aw = awvalid && !awready; p_aw = {awaddr, awlen, awsize, awburst};
            h_w  = wvalid && !wready;   p_w  = {wdata, wstrb, wlast};
            s_ar = arvalid && arready; c_araddr = araddr; c_arlen = arlen;
            s_aw = awvalid && awready; c_awaddr = awaddr; c_awlen = awlen;
            s_w  = wvalid && wready;   c_wdata = wdata;   c_wlast = wlast;
            s_r  = rvalid && rready;
            s_b  = bvalid && bready;
            @(posedge clk);
            #1;
            if (rst) begin
                h_ar = 0; h_aw = 0; h_w = 0; r_act = 0; w_act = 0; b_pend = 0;
                rvalid = 0; bvalid = 0; r_left = 0; w_left = 0;
            end else begin
                if (s_ar) begin
                    r_act = 1; r_addr = c_araddr; r_left = int'(c_arlen) + 1;
                    ar_cnt++; ar_log.push_back(c_araddr); arlen_log.push_back(c_arlen);
                end
                if (s_r) begin
                    r_addr += 4; r_left--; rvalid = 0;
                    if (r_left == 0) r_act = 0;
                end
                if (s_aw) begin
                    w_act = 1; w_addr = c_awaddr; w_left = int'(c_awlen) + 1;
                    aw_cnt++; aw_log.push_back(c_awaddr); awlen_log.push_back(c_awlen);
                end
                if (s_w) begin
                    checks++;
                    if (c_wlast !== (w_left == 1)) begin
                        errors++;
                        $display("FAIL wlast: got %b required %b (beats left %0d)", c_wlast, (w_left == 1), w_left);
                    end
                    smem[w_addr[15:2]] = c_wdata;
                    w_addr += 4; w_left--; w_cnt++;
                    if (w_left == 0) begin w_act = 0; b_pend = 1; end
                end
                if (s_b) begin
                    b_pend = 0; bvalid = 0; b_cnt++;
                end
            end
            arready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            awready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            wready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (force_v) begin
                rvalid = 1; bvalid = 1;
            end else begin
                rvalid = r_act && (rvalid || !rnd || $urandom_range(0, 1) == 1);
                bvalid = b_pend && (bvalid || !rnd || $urandom_range(0, 1) == 1);
            end
            rdata = smem[r_addr[15:2]];
            rlast = (r_left == 1);
            rresp = 2'b00;
            bresp = (b_cnt == bresp_err_at) ? 2'b10 : 2'b00;
        end
    end

    task automatic kick(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        @(negedge clk);
        src_addr = s; dst_addr = d; byte_len = l; start = 1;
    endtask

    // Counts edges from the start edge until done is seen; -1 on timeout.
    task automatic wait_done(input int limit, output int cyc, output logic b_at);
        bit seen;
        seen = 0; cyc = 0; b_at = 1'bx;
        while (!seen && cyc < limit) begin
            @(posedge clk);
            #1;
            start = 0;
            cyc++;
            if (done) begin seen = 1; b_at = busy; end
        end
        if (!seen) cyc = -1;
    endtask

    task automatic clear_dst(input logic [31:0] d, input int words);
        for (int i = 0; i < words; i++) smem[(d >> 2) + i] = 32'h0;
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (3) @(negedge clk);
        checks++;
        if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_axi: got %b required 00000", {arvalid, awvalid, wvalid, rready, bready});
        end
        checks++;
        if ({busy, done, error} !== 3'b0) begin
            errors++;
            $display("FAIL reset_status: got %b required 000", {busy, done, error});
        end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_single;
        int cyc, a0, w0, bad;
        logic b_at;
        clear_dst(32'h2000, 16);
        a0 = ar_cnt; w0 = w_cnt;
        kick(32'h1000, 32'h2000, 16'd64);
        wait_done(200, cyc, b_at);
        checks++;
        if (cyc !== 2 + (1 + 16 + 1 + 16 + 1)) begin
            errors++;
            $display("FAIL single_cycles: got %0d required %0d", cyc, 37);
        end
        checks++;
        if (b_at !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_at_done: got %b required 0", b_at);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL single_done_pulse: got %b required 0", done);
        end
        checks++;
        if (ar_cnt - a0 !== 1 || ar_log[$] !== 32'h1000 || arlen_log[$] !== 8'd15) begin
            errors++;
            $display("FAIL single_ar: got n=%0d addr=%h len=%0d required n=1 addr=00001000 len=15", ar_cnt - a0, ar_log[$], arlen_log[$]);
        end
        checks++;
        if (aw_log[$] !== 32'h2000 || awlen_log[$] !== 8'd15) begin
            errors++;
            $display("FAIL single_aw: got addr=%h len=%0d required addr=00002000 len=15", aw_log[$], awlen_log[$]);
        end
        checks++;
        if (w_cnt - w0 !== 16) begin
            errors++;
            $display("FAIL single_wbeats: got %0d required 16", w_cnt - w0);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) if (smem[(32'h2000 >> 2) + i] !== pat(32'h1000 + 4 * i)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL single_data: got %0d bad words required 0", bad);
        end
    endtask

    task automatic test_unaligned;
        int cyc, a0, aw0, bad;
        logic b_at;
        clear_dst(32'h3000, 10);
        a0 = ar_cnt; aw0 = aw_cnt;
        // Low address bits and byte_len[1:0] are dropped: 10 words from 0x1038 to 0x3000.
        kick(32'h1038, 32'h3003, 16'd43);
        wait_done(200, cyc, b_at);
        checks++;
        if (cyc !== 2 + (1 + 2 + 1 + 2 + 1) + (1 + 8 + 1 + 8 + 1)) begin
            errors++;
            $display("FAIL unal_cycles: got %0d required %0d", cyc, 28);
        end
        checks++;
        if (ar_log.size() < a0 + 2 || ar_cnt - a0 !== 2 || ar_log[a0] !== 32'h1038 || arlen_log[a0] !== 8'd1
            || ar_log[a0 + 1] !== 32'h1040 || arlen_log[a0 + 1] !== 8'd7) begin
            errors++;
            $display("FAIL unal_ar: got n=%0d required 2 bursts 00001038/len1 then 00001040/len7", ar_cnt - a0);
        end
        checks++;
        if (aw_log.size() < aw0 + 2 || aw_cnt - aw0 !== 2 || aw_log[aw0] !== 32'h3000 || awlen_log[aw0] !== 8'd1
            || aw_log[aw0 + 1] !== 32'h3008 || awlen_log[aw0 + 1] !== 8'd7) begin
            errors++;
            $display("FAIL unal_aw: got n=%0d required 2 bursts 00003000/len1 then 00003008/len7", aw_cnt - aw0);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) if (smem[(32'h3000 >> 2) + i] !== pat(32'h1038 + 4 * i)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL unal_data: got %0d bad words required 0", bad);
        end
    endtask

    task automatic test_zero_len;
        int cyc, a0, aw0, w0;
        logic b_at;
        a0 = ar_cnt; aw0 = aw_cnt; w0 = w_cnt;
        force_v = 1;
        kick(32'h1000, 32'h2000, 16'd3);
        wait_done(20, cyc, b_at);
        checks++;
        if (cyc !== 2) begin
            errors++;
            $display("FAIL zero_cycles: got %0d required 2", cyc);
        end
        checks++;
        if (b_at !== 1'b0) begin
            errors++;
            $display("FAIL zero_busy_at_done: got %b required 0", b_at);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (ar_cnt - a0 !== 0 || aw_cnt - aw0 !== 0 || w_cnt - w0 !== 0 || rready !== 1'b0 || bready !== 1'b0) begin
            errors++;
            $display("FAIL zero_traffic: got ar=%0d aw=%0d w=%0d rready=%b bready=%b required all 0",
                     ar_cnt - a0, aw_cnt - aw0, w_cnt - w0, rready, bready);
        end
        force_v = 0;
        @(negedge clk);
    endtask

    task automatic test_random_ready;
        int cyc, a0, w0, bad;
        logic b_at;
        clear_dst(32'h2800, 32);
        a0 = ar_cnt; w0 = w_cnt;
        rnd = 1;
        kick(32'h1100, 32'h2800, 16'd128);
        wait_done(3000, cyc, b_at);
        rnd = 0;
        checks++;
        if (cyc < 0) begin
            errors++;
            $display("FAIL rand_done: got timeout required done pulse");
        end
        checks++;
        if (ar_log.size() < a0 + 2 || ar_cnt - a0 !== 2 || ar_log[a0] !== 32'h1100 || ar_log[a0 + 1] !== 32'h1140) begin
            errors++;
            $display("FAIL rand_ar: got n=%0d required bursts at 00001100 and 00001140", ar_cnt - a0);
        end
        checks++;
        if (w_cnt - w0 !== 32) begin
            errors++;
            $display("FAIL rand_wbeats: got %0d required 32", w_cnt - w0);
        end
        bad = 0;
        for (int i = 0; i < 32; i++) if (smem[(32'h2800 >> 2) + i] !== pat(32'h1100 + 4 * i)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL rand_data: got %0d bad words required 0", bad);
        end
        @(negedge clk);
    endtask

    task automatic test_busy_and_reset;
        int cyc, a0, aw0, w0, k;
        logic b_at;
        a0 = ar_cnt;
        kick(32'h1000, 32'h2400, 16'd64);
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        src_addr = 32'h1200; dst_addr = 32'h2600; byte_len = 16'd8; start = 1;
        @(negedge clk);
        start = 0;
        wait_done(200, cyc, b_at);
        checks++;
        if (cyc < 0) begin
            errors++;
            $display("FAIL busy_done: got timeout required done pulse");
        end
        repeat (10) @(negedge clk);
        checks++;
        if (ar_cnt - a0 !== 1 || ar_log[$] !== 32'h1000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_ignored: got ar=%0d last=%h busy=%b required ar=1 last=00001000 busy=0", ar_cnt - a0, ar_log[$], busy);
        end
        kick(32'h1000, 32'h2C00, 16'd64);
        k = 0;
        while (rready !== 1'b1 && k < 20) begin
            @(posedge clk);
            #1;
            start = 0;
            k++;
        end
        checks++;
        if (rready !== 1'b1) begin
            errors++;
            $display("FAIL rst_reach_rdata: got rready=%b required 1", rready);
        end
        repeat (3) @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        checks++;
        if ({arvalid, awvalid, wvalid, rready, bready, busy, done, error} !== 8'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %b required 00000000", {arvalid, awvalid, wvalid, rready, bready, busy, done, error});
        end
        @(negedge clk);
        rst = 0;
        a0 = ar_cnt; aw0 = aw_cnt; w0 = w_cnt;
        repeat (20) @(negedge clk);
        checks++;
        if (ar_cnt !== a0 || aw_cnt !== aw0 || w_cnt !== w0 || {arvalid, awvalid, wvalid, rready, bready, busy} !== 6'b0) begin
            errors++;
            $display("FAIL rst_idle: got ar=%0d aw=%0d w=%0d sig=%b required no traffic and 000000",
                     ar_cnt - a0, aw_cnt - aw0, w_cnt - w0, {arvalid, awvalid, wvalid, rready, bready, busy});
        end
    endtask

    task automatic test_resp_error;
        int cyc, a0;
        logic b_at;
        a0 = ar_cnt;
        bresp_err_at = b_cnt;
        kick(32'h1000, 32'h3400, 16'd192);
        wait_done(500, cyc, b_at);
        bresp_err_at = -1;
        checks++;
        if (cyc < 0) begin
            errors++;
            $display("FAIL resp_done: got timeout required done pulse");
        end
`ifdef DMAC_ENGINE_RESP_CHECK_EN
        checks++;
        if (error !== 1'b1 || ar_cnt - a0 !== 1) begin
            errors++;
            $display("FAIL resp_abort: got error=%b ar=%0d required error=1 ar=1", error, ar_cnt - a0);
        end
        kick(32'h0, 32'h0, 16'd0);
        wait_done(20, cyc, b_at);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL resp_clear: got error=%b required 0", error);
        end
`else
        checks++;
        if (error !== 1'b0 || ar_cnt - a0 !== 3) begin
            errors++;
            $display("FAIL resp_ignored: got error=%b ar=%0d required error=0 ar=3", error, ar_cnt - a0);
        end
`endif
    endtask

    initial begin
        rst = 1; start = 0; src_addr = 0; dst_addr = 0; byte_len = 0;
        for (int i = 0; i < 16384; i++) smem[i] = pat(32'(i) << 2);
        test_reset();
        test_single();
        test_unaligned();
        test_zero_len();
        test_random_ready();
        test_busy_and_reset();
        test_resp_error();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
